key_debounce8: RTL and testbench
================================

# key_debounce8

Eight-channel synchronizer and debouncer for active-low push-button inputs. It sits directly upstream of the 8-3 priority encoder. Its stable, active-low `oKey` vector drives the encoder's `iData` inputs, so the encoder never sees metastable or bouncing levels. It also provides per-channel press pulses and an any-key-held flag for control logic.

## Interface
Parameters:
- `DEB_CYCLES`, default 1000000: consecutive stable cycles required to accept a new level (10 ms at 100 MHz). Legal range is 2 to 2^`CNT_W`.
- `CNT_W`, default 20: width of each channel's debounce counter. It must hold `DEB_CYCLES-1`.

Ports:
- `iClk`, input, 1: the single clock. All state updates on the rising edge.
- `iRst_n`, input, 1: asynchronous, active-low reset.
- `iKey`, input, 8: raw button pins, asynchronous to `iClk`, active-low (0 = pressed).
- `oKey`, output, 8: debounced stable levels, active-low. Connects to the encoder's `iData`.
- `oPress`, output, 8: one-cycle, active-high pulse per channel on an accepted press (stable 1→0).
- `oAny`, output, 1: high while any `oKey` bit is 0. Equals the reduction NAND of `oKey`.

## Operation
- Each channel has a two-flop synchronizer `s1`, `s2`. Both reset to 1.
- Each channel has a stable register, which drives `oKey[i]` and resets to 1.
- Each channel has a counter `c[i]`, which resets to 0.
- Per-channel rule, evaluated every cycle:
  - `s2[i] == oKey[i]`: `c[i]` <= 0.
  - `s2[i] != oKey[i]` and `c[i] < DEB_CYCLES-1`: `c[i]` <= `c[i]` + 1.
  - `s2[i] != oKey[i]` and `c[i] == DEB_CYCLES-1`: `oKey[i]` <= `s2[i]` and `c[i]` <= 0.
- Glitch rejection: any return of `s2[i]` to `oKey[i]` before acceptance clears `c[i]`. Partial counts never carry over.
- `oPress[i]` is registered and equals 1 only in the cycle where `oKey[i]` has just transitioned 1→0. An accepted release (0→1) produces no pulse.
- Channels are fully independent. Simultaneous accepted presses on several channels assert the corresponding `oPress` bits in the same cycle.
- `oAny` is derived combinationally from the `oKey` register, so it is glitch-free.
- The counter never wraps. It is held at or below `DEB_CYCLES-1` by construction.

## Timing
Reset values, applied immediately on `iRst_n` = 0 regardless of `iClk`:
- `oKey` = 8'hFF
- `oPress` = 8'h00
- `oAny` = 0
- All synchronizers = 1
- All counters = 0

Latency and reset behaviour:
- **Reset release:** the first state change can occur on the first rising edge with `iRst_n` = 1.
- **Latency:** a level change on `iKey[i]` is first sampled on edge 1. It reaches `s2` on edge 2. Counter increments occur on edges 3 … `DEB_CYCLES`+1. `oKey[i]` updates on edge `DEB_CYCLES`+2, provided `iKey[i]` stays constant throughout.
- **`oPress` timing:** `oPress[i]` goes high on the same edge that `oKey[i]` falls. It goes low on the following edge.
- **Reset mid-count:** pending counts are discarded and `oKey` returns to FF. After release, a held key must be re-debounced for the full latency.

## Configuration
- `KEY_PRESS_PULSE_EN` defined:
  - The `oPress` generation logic is compiled in, as described above.
- `KEY_PRESS_PULSE_EN` undefined:
  - The `oPress` port remains but is tied to 8'h00, and its registers are omitted.
  - `oKey` and `oAny` behaviour is unchanged.

## Test plan
All scenarios use `DEB_CYCLES`=4 and `KEY_PRESS_PULSE_EN` defined unless noted.
- **Clean press:** `iKey`=8'hF7 from edge 1 and held → `oKey`=8'hF7 after edge 6, `oPress`=8'h08 for exactly one cycle, `oAny`=1. Feeding this to the encoder with `iEI`=0 gives `oData`=3'b011.
- **Bounce rejection:** `iKey[3]` low for 3 cycles, high 2 cycles, low 3 cycles, then high → `oKey` stays 8'hFF and `oPress` stays 8'h00 throughout.
- **Release:** from the stable 8'hF7 state, `iKey`=8'hFF held → `oKey`=8'hFF after 6 edges, no `oPress` pulse, `oAny`=0.
- **Simultaneous press:** `iKey`=8'h7E held → `oKey`=8'h7E and `oPress`=8'h81 in the same cycle, once.
- **Reset mid-count:** `iKey`=8'hFE, then `iRst_n`=0 asynchronously after 3 edges and released 2 cycles later with `iKey` still 8'hFE → outputs go to reset values immediately. `oKey`=8'hFE is reached 6 edges after release, not earlier.
- **Macro off:** repeat the clean-press scenario without `KEY_PRESS_PULSE_EN` → identical `oKey` and `oAny`, while `oPress` stays 8'h00 throughout.

Source files
------------

// File: rtl/key_debounce8.sv
// key_debounce8: eight-channel synchronizer and debouncer for active-low push buttons.
// Each channel runs a two-flop synchronizer into a saturating stability counter; a new
// level is accepted only after DEB_CYCLES consecutive cycles of disagreement with the
// current stable level.
// Optional feature macro: KEY_PRESS_PULSE_EN enables the registered oPress pulse logic;
// when undefined, oPress is tied to 8'h00.
module key_debounce8 #(
    parameter int unsigned DEB_CYCLES = 1000000,
    parameter int unsigned CNT_W      = 20
) (
    input  logic       iClk,
    input  logic       iRst_n,
    input  logic [7:0] iKey,
    output logic [7:0] oKey,
    output logic [7:0] oPress,
    output logic       oAny
);

    localparam logic [CNT_W-1:0] CntMax = CNT_W'(DEB_CYCLES - 1);

    logic [7:0]       s1_q;
    logic [7:0]       s2_q;
    logic [7:0]       key_q;
    logic [7:0]       key_d;
    logic [CNT_W-1:0] cnt_q [8];
    logic [CNT_W-1:0] cnt_d [8];

    // Two-flop synchronizer; idle (released) level is 1.
    always_ff @(posedge iClk or negedge iRst_n) begin
        if (!iRst_n) begin
            s1_q <= 8'hFF;
            s2_q <= 8'hFF;
        end else begin
            s1_q <= iKey;
            s2_q <= s1_q;
        end
    end

    // Per-channel debounce rule: clear on agreement, count on disagreement, accept at max.
    always_comb begin
        key_d = key_q;
        for (int i = 0; i < 8; i++) begin
            cnt_d[i] = '0;
            if (s2_q[i] != key_q[i]) begin
                if (cnt_q[i] == CntMax) begin
                    key_d[i] = s2_q[i];
                end else begin
                    cnt_d[i] = cnt_q[i] + CNT_W'(1);
                end
            end
        end
    end

    // Stable level and counter state.
    always_ff @(posedge iClk or negedge iRst_n) begin
        if (!iRst_n) begin
            key_q <= 8'hFF;
            for (int i = 0; i < 8; i++) begin
                cnt_q[i] <= '0;
            end
        end else begin
            key_q <= key_d;
            for (int i = 0; i < 8; i++) begin
                cnt_q[i] <= cnt_d[i];
            end
        end
    end

`ifdef KEY_PRESS_PULSE_EN
    logic [7:0] press_q;

    // Pulse in the cycle the stable level has just fallen 1->0; releases give nothing.
    always_ff @(posedge iClk or negedge iRst_n) begin
        if (!iRst_n) begin
            press_q <= 8'h00;
        end else begin
            press_q <= key_q & ~key_d;
        end
    end

    assign oPress = press_q;
`else
    assign oPress = 8'h00;
`endif

    assign oKey = key_q;
    // Derived from the register only, so it cannot glitch.
    assign oAny = ~(&key_q);

endmodule

// File: tb/tb_key_debounce8.sv
// Directed self-checking bench for key_debounce8 with DEB_CYCLES=4.
// Expected oPress values follow KEY_PRESS_PULSE_EN so the same bench covers both builds.
module tb_key_debounce8;

    logic       clk;
    logic       rst_n;
    logic [7:0] key_in;
    logic [7:0] key_out;
    logic [7:0] press;
    logic       any;

    int checks   = 0;
    int failures = 0;

`ifdef KEY_PRESS_PULSE_EN
    localparam bit PulseEn = 1'b1;
`else
    localparam bit PulseEn = 1'b0;
`endif

    key_debounce8 #(
        .DEB_CYCLES(4),
        .CNT_W     (3)
    ) dut (
        .iClk  (clk),
        .iRst_n(rst_n),
        .iKey  (key_in),
        .oKey  (key_out),
        .oPress(press),
        .oAny  (any)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one rising edge and settle 1 time unit after it.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        #3;
        checks++;
        if (key_out !== 8'hFF) begin
            failures++;
            $display("FAIL reset_okey got=%h want=ff", key_out);
        end
        checks++;
        if (press !== 8'h00) begin
            failures++;
            $display("FAIL reset_opress got=%h want=00", press);
        end
        checks++;
        if (any !== 1'b0) begin
            failures++;
            $display("FAIL reset_oany got=%b want=0", any);
        end
        step();
        step();
        rst_n = 1'b1;
        step();
    endtask

    task automatic test_bounce();
        logic [3:0] pat [4];
        int         len [4];
        pat[0] = 1'b0; len[0] = 3;
        pat[1] = 1'b1; len[1] = 2;
        pat[2] = 1'b0; len[2] = 3;
        pat[3] = 1'b1; len[3] = 10;
        for (int p = 0; p < 4; p++) begin
            key_in = pat[p][0] ? 8'hFF : 8'hF7;
            for (int n = 0; n < len[p]; n++) begin
                step();
                checks++;
                if (key_out !== 8'hFF || press !== 8'h00 || any !== 1'b0) begin
                    failures++;
                    $display("FAIL bounce phase=%0d cyc=%0d okey=%h opress=%h oany=%b want ff/00/0",
                             p, n, key_out, press, any);
                end
            end
        end
    endtask

    task automatic test_clean_press();
        logic [7:0] exp_press;
        key_in = 8'hF7;
        for (int e = 1; e <= 7; e++) begin
            step();
            exp_press = (PulseEn && e == 6) ? 8'h08 : 8'h00;
            checks++;
            if (key_out !== ((e >= 6) ? 8'hF7 : 8'hFF)) begin
                failures++;
                $display("FAIL press_okey edge=%0d got=%h want=%h", e, key_out,
                         (e >= 6) ? 8'hF7 : 8'hFF);
            end
            checks++;
            if (press !== exp_press) begin
                failures++;
                $display("FAIL press_opress edge=%0d got=%h want=%h", e, press, exp_press);
            end
            checks++;
            if (any !== (e >= 6)) begin
                failures++;
                $display("FAIL press_oany edge=%0d got=%b want=%b", e, any, (e >= 6));
            end
        end
    endtask

    task automatic test_release();
        key_in = 8'hFF;
        for (int e = 1; e <= 7; e++) begin
            step();
            checks++;
            if (key_out !== ((e >= 6) ? 8'hFF : 8'hF7)) begin
                failures++;
                $display("FAIL release_okey edge=%0d got=%h want=%h", e, key_out,
                         (e >= 6) ? 8'hFF : 8'hF7);
            end
            checks++;
            if (press !== 8'h00) begin
                failures++;
                $display("FAIL release_opress edge=%0d got=%h want=00", e, press);
            end
            checks++;
            if (any !== (e < 6)) begin
                failures++;
                $display("FAIL release_oany edge=%0d got=%b want=%b", e, any, (e < 6));
            end
        end
    endtask

    task automatic test_simultaneous();
        logic [7:0] exp_press;
        key_in = 8'h7E;
        for (int e = 1; e <= 7; e++) begin
            step();
            exp_press = (PulseEn && e == 6) ? 8'h81 : 8'h00;
            checks++;
            if (key_out !== ((e >= 6) ? 8'h7E : 8'hFF)) begin
                failures++;
                $display("FAIL simul_okey edge=%0d got=%h want=%h", e, key_out,
                         (e >= 6) ? 8'h7E : 8'hFF);
            end
            checks++;
            if (press !== exp_press) begin
                failures++;
                $display("FAIL simul_opress edge=%0d got=%h want=%h", e, press, exp_press);
            end
        end
        key_in = 8'hFF;
        for (int e = 0; e < 8; e++) step();
        checks++;
        if (key_out !== 8'hFF || any !== 1'b0) begin
            failures++;
            $display("FAIL simul_idle okey=%h oany=%b want ff/0", key_out, any);
        end
    endtask

    task automatic test_reset_mid_count();
        key_in = 8'hFE;
        step();
        step();
        step();
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if (key_out !== 8'hFF || press !== 8'h00 || any !== 1'b0) begin
            failures++;
            $display("FAIL midrst_async okey=%h opress=%h oany=%b want ff/00/0",
                     key_out, press, any);
        end
        step();
        step();
        #2;
        rst_n = 1'b1;
        for (int e = 1; e <= 6; e++) begin
            step();
            checks++;
            if (key_out !== ((e >= 6) ? 8'hFE : 8'hFF)) begin
                failures++;
                $display("FAIL midrst_okey edge=%0d got=%h want=%h", e, key_out,
                         (e >= 6) ? 8'hFE : 8'hFF);
            end
        end
        checks++;
        if (press !== (PulseEn ? 8'h01 : 8'h00) || any !== 1'b1) begin
            failures++;
            $display("FAIL midrst_press opress=%h oany=%b want=%h/1", press, any,
                     PulseEn ? 8'h01 : 8'h00);
        end
    endtask

    initial begin
        rst_n  = 1'b1;
        key_in = 8'hFF;
        #1;
        rst_n = 1'b0;
        test_reset();
        test_bounce();
        test_clean_press();
        test_release();
        test_simultaneous();
        test_reset_mid_count();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
